// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_pkg
//  Purpose  : Shared clocking constants and the frequency-meter state type.
//  Contents : CLK_HZ_DEFAULT - fabric clock frequency (Hz)
//             GATE_1S        - gate length giving a 1 s window at that clock
//             meter_state_t  - IDLE / GATE state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package clk_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int GATE_1S        = CLK_HZ_DEFAULT;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_detect
//  Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//             third flop that turns a low-to-high transition into a pulse.
//  Ports    : clk      - system clock
//             rst      - synchronous active-high reset
//             async_in - asynchronous input
//             rise     - one-cycle pulse per rising edge of async_in
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Built only from flops that run continuously, so the pulse never
    // depends on whether a consumer happens to be listening.
    assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Gated frequency counter. Counts rising edges of sig_in over
//             windows of GATE_CYCLES clocks and reports one count per window.
//  Ports    : clk        - system clock
//             rst        - synchronous active-high reset
//             en         - measurement enable (level)
//             sig_in     - asynchronous signal under measurement
//             meas_count - edge count of the last completed window
//             meas_ovf   - last completed window lost edges to saturation
//             meas_valid - one-cycle pulse when meas_count/meas_ovf update
//             busy       - a window is open
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meter
    import clk_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_ovf,
    output logic             meas_valid,
    output logic             busy
);

    localparam int               c_gate_w  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_gate_w-1:0] c_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    meter_state_t        r_state;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf_acc;

    logic                w_rise;
    logic                w_sat_hit;
    logic [CNT_W-1:0]    w_cnt_next;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .rise     (w_rise)
    );

    // An edge that arrives with the counter already at full scale is lost;
    // that loss is what the overflow flag reports.
    assign w_sat_hit  = w_rise & (r_edge_cnt == c_cnt_max);
    assign w_cnt_next = (w_rise && !w_sat_hit) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
            meas_count <= '0;
            meas_ovf   <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_acc  <= 1'b0;
                    if (en) begin
                        r_state <= GATE;
                    end
                end
                GATE: begin
                    if (r_gate_cnt == c_last) begin
                        // Terminal cycle: the edge seen now still belongs
                        // to this window, and the result is delivered even
                        // if en has just dropped.
                        meas_count <= w_cnt_next;
                        meas_ovf   <= r_ovf_acc | w_sat_hit;
                        meas_valid <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_state    <= en ? GATE : IDLE;
                    end else if (!en) begin
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                        r_edge_cnt <= w_cnt_next;
                        if (w_sat_hit) begin
                            r_ovf_acc <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == GATE);

endmodule
`default_nettype wire
